// File: rtl/time_adjust_ctrl.sv
// Enable/direction sequencer for the alarm clock counters: 1 Hz time base with
// carries in run mode, debounced-button single/auto-repeat adjust in set modes.
module time_adjust_ctrl #(
  parameter int SEC_MOD     = 60,
  parameter int MIN_MOD     = 60,
  parameter int HOLD_CYCLES = 50,
  parameter int RATE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] sec_count,
  input  logic [5:0] min_count,
  output logic       en_sec,
  output logic       en_min,
  output logic       en_hour,
  output logic       en_amin,
  output logic       en_ahour,
  output logic       updown,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_HOUR  = 3'd1,
    SET_MIN   = 3'd2,
    SET_AHOUR = 3'd3,
    SET_AMIN  = 3'd4
  } mode_e;

  localparam int CW = $clog2(HOLD_CYCLES + RATE_CYCLES + 1);
  localparam logic [CW-1:0] FIRST_REP = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] NEXT_REP  = CW'(HOLD_CYCLES + RATE_CYCLES - 1);
  localparam logic [CW-1:0] RELOAD    = CW'(HOLD_CYCLES);

  // {mode, up, down} synchronizer stages
  logic [2:0]    s1_q, s2_q;
  logic          pm_q, act_p_q, dir_p_q;
  mode_e         mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_sec_q, en_min_q, en_hour_q, en_amin_q, en_ahour_q, updown_q;
  logic          en_sec_d, en_min_d, en_hour_d, en_amin_d, en_ahour_d, updown_d;

  logic rise_m, act, dir, press, rep, adj, time_act, tfire, sec_wrap, min_wrap;

  // Exactly one of up/down counts as a press; a change of which one is a new press.
  always_comb begin
    rise_m   = s2_q[2] & ~pm_q;
    act      = s2_q[1] ^ s2_q[0];
    dir      = s2_q[1];
    press    = act & (~act_p_q | (dir != dir_p_q));
    rep      = act & ~press & ((cnt_q == FIRST_REP) | (cnt_q == NEXT_REP));
    adj      = act & (mode_q != RUN) & ~rise_m & (press | rep);
    time_act = (mode_q == RUN) | (mode_q == SET_AHOUR) | (mode_q == SET_AMIN);
    // a down-adjust shares the updown line, so the time-base strobes must drop
    tfire    = tick_1hz & time_act & ~(adj & ~dir);
    sec_wrap = (sec_count == 6'(SEC_MOD - 1));
    min_wrap = (min_count == 6'(MIN_MOD - 1));

    en_sec_d   = tfire;
    en_min_d   = (tfire & sec_wrap) | (adj & (mode_q == SET_MIN));
    en_hour_d  = (tfire & sec_wrap & min_wrap) | (adj & (mode_q == SET_HOUR));
    en_amin_d  = adj & (mode_q == SET_AMIN);
    en_ahour_d = adj & (mode_q == SET_AHOUR);
    updown_d   = adj ? dir : 1'b1;

    cnt_d = cnt_q + CW'(1);
    if (!act || rise_m || press) cnt_d = '0;
    else if (cnt_q == NEXT_REP)  cnt_d = RELOAD;

    mode_d = mode_q;
    case (mode_q)
      RUN:       if (rise_m) mode_d = SET_HOUR;
      SET_HOUR:  if (rise_m) mode_d = SET_MIN;
      SET_MIN:   if (rise_m) mode_d = SET_AHOUR;
      SET_AHOUR: if (rise_m) mode_d = SET_AMIN;
      SET_AMIN:  if (rise_m) mode_d = RUN;
      default:   mode_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      pm_q       <= 1'b0;
      act_p_q    <= 1'b0;
      dir_p_q    <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= RUN;
      en_sec_q   <= 1'b0;
      en_min_q   <= 1'b0;
      en_hour_q  <= 1'b0;
      en_amin_q  <= 1'b0;
      en_ahour_q <= 1'b0;
      updown_q   <= 1'b1;
    end else begin
      s1_q       <= {btn_mode, btn_up, btn_down};
      s2_q       <= s1_q;
      pm_q       <= s2_q[2];
      act_p_q    <= act;
      dir_p_q    <= dir;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      en_sec_q   <= en_sec_d;
      en_min_q   <= en_min_d;
      en_hour_q  <= en_hour_d;
      en_amin_q  <= en_amin_d;
      en_ahour_q <= en_ahour_d;
      updown_q   <= updown_d;
    end
  end

  assign en_sec   = en_sec_q;
  assign en_min   = en_min_q;
  assign en_hour  = en_hour_q;
  assign en_amin  = en_amin_q;
  assign en_ahour = en_ahour_q;
  assign updown   = updown_q;
  assign mode     = mode_q;

endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Bench for time_adjust_ctrl: tick table plus button sequences, strobes scored
// against a queue of expected {cycle, enables, direction} records.
module tb_time_adjust_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [5:0] sec_count = '0, min_count = '0;
  logic       en_sec, en_min, en_hour, en_amin, en_ahour, updown;
  logic [2:0] mode;

  time_adjust_ctrl dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .sec_count(sec_count), .min_count(min_count),
    .en_sec(en_sec), .en_min(en_min), .en_hour(en_hour),
    .en_amin(en_amin), .en_ahour(en_ahour), .updown(updown), .mode(mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {sec, min, hour, amin, ahour}
  wire [4:0] en_v = {en_sec, en_min, en_hour, en_amin, en_ahour};

  typedef struct {
    int         cyc;
    logic [4:0] en;
    logic       ud;
  } exp_t;

  typedef struct {
    int         md;
    logic [5:0] sec;
    logic [5:0] mn;
    logic [2:0] exp_en;   // {sec, min, hour}
  } tv_t;

  exp_t sbq[$];
  exp_t mx;
  tv_t  tv[8];
  int   errs = 0, checks = 0;
  int   cur_mode = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_strobe(input int c, input logic [4:0] e, input logic u);
    exp_t x;
    x.cyc = c; x.en = e; x.ud = u;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      mx = sbq.pop_front();
      checks++; errs++;
      $display("FAIL missing_strobe: cycle %0d got none expected en=%b ud=%b", mx.cyc, mx.en, mx.ud);
    end
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      mx = sbq.pop_front();
      checks++;
      if (en_v !== mx.en || updown !== mx.ud) begin
        errs++;
        $display("FAIL strobe: cycle %0d got en=%b ud=%b expected en=%b ud=%b",
                 cyc, en_v, updown, mx.en, mx.ud);
      end
    end else if (en_v !== 5'b0) begin
      checks++; errs++;
      $display("FAIL unexpected_strobe: cycle %0d got en=%b expected en=00000", cyc, en_v);
    end
  end

  function automatic logic [4:0] field_mask(input int m);
    case (m)
      1:       return 5'b00100;
      2:       return 5'b01000;
      3:       return 5'b00001;
      4:       return 5'b00010;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic press_mode();
    btn_mode = 1'b1;
    repeat (2) @(negedge clk);
    btn_mode = 1'b0;
    chk("mode_before_edge", int'(mode), cur_mode);
    @(negedge clk);
    cur_mode = (cur_mode + 1) % 5;
    chk("mode_step", int'(mode), cur_mode);
    repeat (2) @(negedge clk);
  endtask

  task automatic goto_mode(input int t);
    while (cur_mode != t) press_mode();
  endtask

  task automatic count_strobes(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (en_v !== 5'b0) hits++;
    end
  endtask

  initial begin
    int c0, hits;

    tv[0] = '{0, 6'd59, 6'd59, 3'b111};
    tv[1] = '{0, 6'd10, 6'd59, 3'b100};
    tv[2] = '{0, 6'd59, 6'd10, 3'b110};
    tv[3] = '{0, 6'd0,  6'd0,  3'b100};
    tv[4] = '{1, 6'd59, 6'd59, 3'b000};
    tv[5] = '{2, 6'd59, 6'd0,  3'b000};
    tv[6] = '{3, 6'd59, 6'd59, 3'b111};
    tv[7] = '{4, 6'd58, 6'd59, 3'b100};

    // reset with up held; RUN then ignores it
    btn_up = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_en", int'(en_v), 0);
      chk("reset_updown", int'(updown), 1);
      chk("reset_mode", int'(mode), 0);
    end
    reset = 1'b1;
    count_strobes(10, hits);
    chk("run_ignores_up", hits, 0);
    btn_up = 1'b0;
    repeat (4) @(negedge clk);

    // time base across modes
    for (int i = 0; i < 8; i++) begin
      goto_mode(tv[i].md);
      sec_count = tv[i].sec;
      min_count = tv[i].mn;
      tick_1hz  = 1'b1;
      c0 = cyc;
      if (tv[i].exp_en != 3'b000) expect_strobe(c0 + 1, {tv[i].exp_en, 2'b00}, 1'b1);
      @(negedge clk);
      tick_1hz = 1'b0;
      if (tv[i].exp_en == 3'b000) chk("tick_halted", int'(en_v), 0);
      repeat (3) @(negedge clk);
    end

    // single up press in SET_HOUR, 3-clock latency
    goto_mode(1);
    c0 = cyc;
    btn_up = 1'b1;
    expect_strobe(c0 + 3, field_mask(1), 1'b1);
    repeat (2) @(negedge clk);
    btn_up = 1'b0;
    repeat (5) @(negedge clk);

    // mode and up rise together: mode wins
    btn_mode = 1'b1; btn_up = 1'b1;
    repeat (2) @(negedge clk);
    btn_mode = 1'b0;
    @(negedge clk);
    cur_mode = 2;
    chk("mode_wins_mode", int'(mode), 2);
    count_strobes(3, hits);
    btn_up = 1'b0;
    chk("mode_wins_nostrobe", hits, 0);
    repeat (4) @(negedge clk);

    // down held 83 clocks in SET_MIN: one press plus four repeats
    c0 = cyc;
    btn_down = 1'b1;
    expect_strobe(c0 + 3,  field_mask(2), 1'b0);
    expect_strobe(c0 + 53, field_mask(2), 1'b0);
    expect_strobe(c0 + 63, field_mask(2), 1'b0);
    expect_strobe(c0 + 73, field_mask(2), 1'b0);
    expect_strobe(c0 + 83, field_mask(2), 1'b0);
    repeat (83) @(negedge clk);
    btn_down = 1'b0;
    count_strobes(6, hits);
    chk("release_stops_repeat", hits, 0);

    // SET_AHOUR: up adjust coincides with a carrying tick
    goto_mode(3);
    c0 = cyc;
    sec_count = 6'd59; min_count = 6'd59;
    btn_up = 1'b1;
    expect_strobe(c0 + 3, 5'b11101, 1'b1);
    repeat (2) @(negedge clk);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0; btn_up = 1'b0;
    repeat (5) @(negedge clk);

    // down adjust coinciding with a tick: tick dropped
    c0 = cyc;
    btn_down = 1'b1;
    expect_strobe(c0 + 3, field_mask(3), 1'b0);
    repeat (2) @(negedge clk);
    tick_1hz = 1'b1;
    @(negedge clk);
    tick_1hz = 1'b0; btn_down = 1'b0;
    repeat (5) @(negedge clk);

    // SET_AMIN: both held gives nothing; dropping down restarts up as a press
    goto_mode(4);
    btn_up = 1'b1; btn_down = 1'b1;
    count_strobes(100, hits);
    chk("both_held_nostrobe", hits, 0);
    c0 = cyc;
    btn_down = 1'b0;
    expect_strobe(c0 + 3, field_mask(4), 1'b1);
    repeat (6) @(negedge clk);
    btn_up = 1'b0;
    repeat (5) @(negedge clk);

    // reset in the middle of a hold; mode held across release counts as a press
    goto_mode(2);
    c0 = cyc;
    btn_down = 1'b1;
    expect_strobe(c0 + 3, field_mask(2), 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b0; btn_mode = 1'b1;
    @(negedge clk);
    chk("midhold_reset_mode", int'(mode), 0);
    chk("midhold_reset_en", int'(en_v), 0);
    chk("midhold_reset_updown", int'(updown), 1);
    reset = 1'b1;
    cur_mode = 0;
    count_strobes(3, hits);
    cur_mode = 1;
    chk("post_reset_mode_press", int'(mode), 1);
    chk("post_reset_nostrobe", hits, 0);
    btn_mode = 1'b0; btn_down = 1'b0;
    repeat (5) @(negedge clk);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
